// File: rtl/hazard_ctrl_if.sv
// Request and status bundle between the pipeline and the hazard controller.
// The slave modport is the controller's view; master is the pipeline's view.
interface hazard_ctrl_if #(
  parameter int STAGES = 6,
  parameter int NREQ   = 2,
  parameter int SIDX_W = 3,
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);
  logic [NREQ-1:0]        req_stall;
  logic [NREQ*SIDX_W-1:0] req_stage;
  logic                   mc_start;
  logic [CNT_W-1:0]       mc_cycles;
  logic [SIDX_W-1:0]      mc_stage;
  logic                   flush_req;
  logic [SIDX_W-1:0]      flush_stage;
  logic [STAGES-1:0]      stall_o;
  logic [STAGES-1:0]      flush_o;
  logic                   mc_busy;
  logic                   mc_err;
  logic [PERF_W-1:0]      stall_cycles;

  modport master (
    output req_stall, req_stage, mc_start, mc_cycles, mc_stage, flush_req, flush_stage,
    input  stall_o, flush_o, mc_busy, mc_err, stall_cycles
  );

  modport slave (
    input  req_stall, req_stage, mc_start, mc_cycles, mc_stage, flush_req, flush_stage,
    output stall_o, flush_o, mc_busy, mc_err, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller. Merges single-cycle stall requests, one
// multi-cycle stall source and one branch flush into per-stage hold/clear masks.
// Stage 0 is the PC; a stall at stage k holds stages k..0.
module hazard_ctrl #(
  parameter int STAGES = 6,
  parameter int NREQ   = 2,
  parameter int SIDX_W = 3,
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {MC_IDLE = 1'b0, MC_BUSY = 1'b1} mc_state_t;
  typedef enum logic {FL_NONE = 1'b0, FL_PEND = 1'b1} fl_state_t;

  // Bits [k:0] set; any k at or beyond the last stage yields all ones.
  function automatic logic [STAGES-1:0] stage_mask(input logic [SIDX_W-1:0] k);
    logic [STAGES-1:0] m;
    m = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      m[i] = (i <= int'(k));
    end
    return m;
  endfunction

  // Map a stage index onto a valid stall bit (out-of-range means last stage).
  function automatic logic [SIDX_W-1:0] clamp_idx(input logic [SIDX_W-1:0] k);
    logic [SIDX_W-1:0] r;
    if (int'(k) > STAGES - 1) begin
      r = SIDX_W'(STAGES - 1);
    end else begin
      r = k;
    end
    return r;
  endfunction

  localparam logic [STAGES-1:0] NO_PC = ~(STAGES'(1));

  mc_state_t         mc_state_r, mc_state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [SIDX_W-1:0] mc_stage_r, mc_stage_s;
  logic              mc_err_r, mc_err_s;
  fl_state_t         fl_state_r, fl_state_s;
  logic [SIDX_W-1:0] fs_r, fs_s;
  logic [PERF_W-1:0] perf_r;
  logic [STAGES-1:0] stall_s;
  logic [STAGES-1:0] flush_s;

  // Same-cycle stall mask: OR of all request masks plus the multi-cycle hold.
  always_comb begin
    stall_s = {STAGES{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      stall_s = stall_s | (stage_mask(bus.req_stage[i*SIDX_W +: SIDX_W])
                           & {STAGES{bus.req_stall[i]}});
    end
    stall_s = stall_s | (stage_mask(mc_stage_r) & {STAGES{mc_state_r == MC_BUSY}});
    stall_s = stall_s & {STAGES{~rst}};
  end

  // Multi-cycle stall FSM: next state, down-counter and reject pulse.
  always_comb begin
    mc_state_s = mc_state_r;
    cnt_s      = cnt_r;
    mc_stage_s = mc_stage_r;
    mc_err_s   = 1'b0;
    case (mc_state_r)
      MC_IDLE: begin
        if (bus.mc_start && (bus.mc_cycles != {CNT_W{1'b0}})) begin
          mc_state_s = MC_BUSY;
          cnt_s      = bus.mc_cycles - CNT_W'(1);
          mc_stage_s = bus.mc_stage;
        end else begin
          mc_state_s = MC_IDLE;
        end
      end
      MC_BUSY: begin
        mc_err_s = bus.mc_start;
        if (cnt_r == {CNT_W{1'b0}}) begin
          mc_state_s = MC_IDLE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        mc_state_s = MC_IDLE;
        cnt_s      = {CNT_W{1'b0}};
      end
    endcase
  end

  // Flush FSM: flush now if the target stage is free, else remember it until it is.
  // The flush mask is also cleared wherever a stall holds, so stall always wins.
  always_comb begin
    fl_state_s = fl_state_r;
    fs_s       = fs_r;
    flush_s    = {STAGES{1'b0}};
    case (fl_state_r)
      FL_NONE: begin
        if (bus.flush_req) begin
          if (stall_s[clamp_idx(bus.flush_stage)]) begin
            fl_state_s = FL_PEND;
            fs_s       = bus.flush_stage;
          end else begin
            flush_s = stage_mask(bus.flush_stage) & NO_PC & ~stall_s;
          end
        end else begin
          fl_state_s = FL_NONE;
        end
      end
      FL_PEND: begin
        if (!stall_s[clamp_idx(fs_r)]) begin
          flush_s    = stage_mask(fs_r) & NO_PC & ~stall_s;
          fl_state_s = FL_NONE;
        end else begin
          fl_state_s = FL_PEND;
        end
      end
      default: begin
        fl_state_s = FL_NONE;
      end
    endcase
    flush_s = flush_s & {STAGES{~rst}};
  end

  // State registers for both FSMs and the registered reject pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_state_r <= MC_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      mc_stage_r <= {SIDX_W{1'b0}};
      mc_err_r   <= 1'b0;
      fl_state_r <= FL_NONE;
      fs_r       <= {SIDX_W{1'b0}};
    end else begin
      mc_state_r <= mc_state_s;
      cnt_r      <= cnt_s;
      mc_stage_r <= mc_stage_s;
      mc_err_r   <= mc_err_s;
      fl_state_r <= fl_state_s;
      fs_r       <= fs_s;
    end
  end

  // Saturating count of cycles in which any stage was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_r <= {PERF_W{1'b0}};
    end else if ((|stall_s) && (perf_r != {PERF_W{1'b1}})) begin
      perf_r <= perf_r + PERF_W'(1);
    end else begin
      perf_r <= perf_r;
    end
  end

  assign bus.stall_o      = stall_s;
  assign bus.flush_o      = flush_s;
  assign bus.mc_busy      = (mc_state_r == MC_BUSY);
  assign bus.mc_err       = mc_err_r;
  assign bus.stall_cycles = perf_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one task per feature, inline comparisons.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.STAGES(6), .NREQ(2), .SIDX_W(3), .CNT_W(6), .PERF_W(32)) bus ();
  hazard_ctrl_if #(.STAGES(6), .NREQ(2), .SIDX_W(3), .CNT_W(6), .PERF_W(4))  pbus ();

  hazard_ctrl #(.STAGES(6), .NREQ(2), .SIDX_W(3), .CNT_W(6), .PERF_W(32)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  hazard_ctrl #(.STAGES(6), .NREQ(2), .SIDX_W(3), .CNT_W(6), .PERF_W(4)) u_perf (
    .clk(clk), .rst(rst), .bus(pbus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_stall = 2'b00;  bus.req_stage = 6'd0;  bus.mc_start = 1'b0;
    bus.mc_cycles = 6'd0;   bus.mc_stage = 3'd0;   bus.flush_req = 1'b0;
    bus.flush_stage = 3'd0;
    pbus.req_stall = 2'b00; pbus.req_stage = 6'd0; pbus.mc_start = 1'b0;
    pbus.mc_cycles = 6'd0;  pbus.mc_stage = 3'd0;  pbus.flush_req = 1'b0;
    pbus.flush_stage = 3'd0;
  endtask

  task automatic test_reset_state();
    bus.req_stall = 2'b01; bus.req_stage = 6'd2;
    tick();
    #1;
    total++; if (bus.stall_o !== 6'b000000) begin bad++; $display("FAIL rst_stall got=%b exp=000000", bus.stall_o); end
    total++; if (bus.flush_o !== 6'b000000) begin bad++; $display("FAIL rst_flush got=%b exp=000000", bus.flush_o); end
    total++; if (bus.mc_busy !== 1'b0 || bus.mc_err !== 1'b0) begin bad++; $display("FAIL rst_mc got=%b%b exp=00", bus.mc_busy, bus.mc_err); end
    total++; if (bus.stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_perf got=%0d exp=0", bus.stall_cycles); end
    total++; if (pbus.stall_cycles !== 4'd0) begin bad++; $display("FAIL rst_perf4 got=%0d exp=0", pbus.stall_cycles); end
    bus.req_stall = 2'b00; bus.req_stage = 6'd0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_stall();
    bus.req_stall = 2'b01; bus.req_stage = {3'd0, 3'd2}; #1;
    total++; if (bus.stall_o !== 6'b000111) begin bad++; $display("FAIL stall_s2 got=%b exp=000111", bus.stall_o); end
    tick();
    bus.req_stall = 2'b11; bus.req_stage = {3'd1, 3'd2}; #1;
    total++; if (bus.stall_o !== 6'b000111) begin bad++; $display("FAIL stall_s2s1 got=%b exp=000111", bus.stall_o); end
    tick();
    bus.req_stall = 2'b01; bus.req_stage = {3'd1, 3'd7}; #1;
    total++; if (bus.stall_o !== 6'b111111) begin bad++; $display("FAIL stall_s7 got=%b exp=111111", bus.stall_o); end
    tick();
    bus.req_stall = 2'b10; bus.req_stage = {3'd4, 3'd7}; #1;
    total++; if (bus.stall_o !== 6'b011111) begin bad++; $display("FAIL stall_src1 got=%b exp=011111", bus.stall_o); end
    tick();
    bus.req_stall = 2'b00; #1;
    total++; if (bus.stall_o !== 6'b000000) begin bad++; $display("FAIL stall_none got=%b exp=000000", bus.stall_o); end
    total++; if (bus.stall_cycles !== 32'd4) begin bad++; $display("FAIL perf_count got=%0d exp=4", bus.stall_cycles); end
    tick();
  endtask

  task automatic test_multicycle();
    bus.mc_start = 1'b1; bus.mc_cycles = 6'd3; bus.mc_stage = 3'd3; #1;
    total++; if (bus.stall_o !== 6'b000000 || bus.mc_busy !== 1'b0) begin bad++; $display("FAIL mc_c0 got=%b/%b exp=000000/0", bus.stall_o, bus.mc_busy); end
    tick();
    bus.mc_start = 1'b0; bus.mc_stage = 3'd0; #1;
    total++; if (bus.stall_o !== 6'b001111 || bus.mc_busy !== 1'b1) begin bad++; $display("FAIL mc_c1 got=%b/%b exp=001111/1", bus.stall_o, bus.mc_busy); end
    tick();
    bus.mc_start = 1'b1; bus.mc_cycles = 6'd5; #1;
    total++; if (bus.stall_o !== 6'b001111 || bus.mc_err !== 1'b0) begin bad++; $display("FAIL mc_c2 got=%b/%b exp=001111/0", bus.stall_o, bus.mc_err); end
    tick();
    bus.mc_start = 1'b0; #1;
    total++; if (bus.stall_o !== 6'b001111 || bus.mc_err !== 1'b1) begin bad++; $display("FAIL mc_c3 got=%b/%b exp=001111/1", bus.stall_o, bus.mc_err); end
    tick();
    total++; if (bus.stall_o !== 6'b000000 || bus.mc_busy !== 1'b0 || bus.mc_err !== 1'b0) begin bad++; $display("FAIL mc_c4 got=%b/%b/%b exp=000000/0/0", bus.stall_o, bus.mc_busy, bus.mc_err); end
    bus.mc_start = 1'b1; bus.mc_cycles = 6'd0; bus.mc_stage = 3'd4;
    tick();
    bus.mc_start = 1'b0; #1;
    total++; if (bus.stall_o !== 6'b000000 || bus.mc_busy !== 1'b0 || bus.mc_err !== 1'b0) begin bad++; $display("FAIL mc_zero got=%b/%b/%b exp=000000/0/0", bus.stall_o, bus.mc_busy, bus.mc_err); end
    tick();
  endtask

  task automatic test_flush_immediate();
    bus.flush_req = 1'b1; bus.flush_stage = 3'd2; #1;
    total++; if (bus.flush_o !== 6'b000110) begin bad++; $display("FAIL flush_s2 got=%b exp=000110", bus.flush_o); end
    tick();
    bus.flush_req = 1'b0; #1;
    total++; if (bus.flush_o !== 6'b000000) begin bad++; $display("FAIL flush_once got=%b exp=000000", bus.flush_o); end
    tick();
    bus.flush_req = 1'b1; bus.flush_stage = 3'd0; #1;
    total++; if (bus.flush_o !== 6'b000000) begin bad++; $display("FAIL flush_pc got=%b exp=000000", bus.flush_o); end
    tick();
    bus.flush_stage = 3'd7; #1;
    total++; if (bus.flush_o !== 6'b111110) begin bad++; $display("FAIL flush_s7 got=%b exp=111110", bus.flush_o); end
    tick();
    bus.flush_req = 1'b0; bus.flush_stage = 3'd0;
    tick();
  endtask

  task automatic test_flush_deferred();
    bus.req_stall = 2'b01; bus.req_stage = {3'd0, 3'd4};
    bus.flush_req = 1'b1; bus.flush_stage = 3'd2; #1;
    total++; if (bus.stall_o !== 6'b011111 || bus.flush_o !== 6'b000000) begin bad++; $display("FAIL dfl_c0 got=%b/%b exp=011111/000000", bus.stall_o, bus.flush_o); end
    tick();
    bus.flush_stage = 3'd5; #1;
    total++; if (bus.flush_o !== 6'b000000) begin bad++; $display("FAIL dfl_c1 got=%b exp=000000", bus.flush_o); end
    tick();
    bus.req_stall = 2'b00; bus.flush_req = 1'b0; bus.flush_stage = 3'd0; #1;
    total++; if (bus.flush_o !== 6'b000110) begin bad++; $display("FAIL dfl_release got=%b exp=000110", bus.flush_o); end
    tick();
    total++; if (bus.flush_o !== 6'b000000) begin bad++; $display("FAIL dfl_after got=%b exp=000000", bus.flush_o); end
    tick();
  endtask

  task automatic test_perf_sat();
    pbus.req_stall = 2'b01; pbus.req_stage = 6'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) begin
        total++; if (pbus.stall_cycles !== 4'd15) begin bad++; $display("FAIL perf_at15 got=%0d exp=15", pbus.stall_cycles); end
      end
    end
    total++; if (pbus.stall_cycles !== 4'd15) begin bad++; $display("FAIL perf_sat got=%0d exp=15", pbus.stall_cycles); end
    pbus.req_stall = 2'b00;
    tick();
    total++; if (pbus.stall_cycles !== 4'd15) begin bad++; $display("FAIL perf_hold got=%0d exp=15", pbus.stall_cycles); end
  endtask

  task automatic test_reset();
    bus.mc_start = 1'b1; bus.mc_cycles = 6'd10; bus.mc_stage = 3'd2;
    tick();
    bus.mc_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.req_stall = 2'b01; bus.req_stage = {3'd0, 3'd3}; #1;
    total++; if (bus.mc_busy !== 1'b1 || bus.stall_o !== 6'b001111) begin bad++; $display("FAIL pre_rst got=%b/%b exp=1/001111", bus.mc_busy, bus.stall_o); end
    rst = 1'b1; #1;
    total++; if (bus.stall_o !== 6'b000000 || bus.flush_o !== 6'b000000) begin bad++; $display("FAIL async_rst_masks got=%b/%b exp=0/0", bus.stall_o, bus.flush_o); end
    total++; if (bus.mc_busy !== 1'b0 || bus.mc_err !== 1'b0 || bus.stall_cycles !== 32'd0) begin bad++; $display("FAIL async_rst_regs got=%b/%b/%0d exp=0/0/0", bus.mc_busy, bus.mc_err, bus.stall_cycles); end
    total++; if (pbus.stall_cycles !== 4'd0) begin bad++; $display("FAIL async_rst_perf4 got=%0d exp=0", pbus.stall_cycles); end
    tick();
    bus.req_stall = 2'b00; rst = 1'b0;
    tick();
    total++; if (bus.mc_busy !== 1'b0 || bus.stall_cycles !== 32'd0 || bus.stall_o !== 6'b000000) begin bad++; $display("FAIL post_rst got=%b/%0d/%b exp=0/0/000000", bus.mc_busy, bus.stall_cycles, bus.stall_o); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset_state();
    test_single_stall();
    test_multicycle();
    test_flush_immediate();
    test_flush_deferred();
    test_perf_sat();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
